// File: rtl/graph_pkg.sv
// Purpose: shared constants and FSM encoding for the graph data store and its renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package graph_pkg;

    localparam int GRAPH_ADDR_W   = 8;    // bin address width
    localparam int GRAPH_DATA_W   = 9;    // bin magnitude width (renderer value range)
    localparam int GRAPH_NUM_BINS = 256;  // bins per frame, <= 2**GRAPH_ADDR_W

    // FILL: back bank accepting a frame; DONE: complete frame waiting for vsync.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_DONE = 1'b1
    } graph_state_e;

endpackage

// File: rtl/graph_bank_ram.sv
// Purpose: simple dual-port RAM, one write port, one registered read port (EBR-friendly).
// Latency: read data valid 1 cycle after i_rd_addr; write lands on the clock edge.
// Backpressure: none; always accepts a write and a read every cycle.
// Ports: i_clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_addr -> o_rd_data read port.
module graph_bank_ram #(
    parameter int AW = 9,
    parameter int DW = 9
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    // No reset on the array or read register so the tools can map this onto block RAM.
    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rd_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_q;

endmodule

// File: rtl/graph_bank_ctrl.sv
// Purpose: ping-pong bank controller; producer fills the back bank, renderer reads the front bank,
//          banks swap only on the vsync falling edge. Ports: producer valid/ready/data/last stream,
//          renderer rd_addr -> rd_data, vsync/freeze control, swap/front/error/drop status.
// Latency: rd_data 1 cycle after rd_addr; swap_pulse/front_bank update 1 cycle after the vsync fall.
// Backpressure: wr_ready drops once a frame is complete and stays low until the next bank swap.
module graph_bank_ctrl
    import graph_pkg::*;
#(
    parameter int NUM_BINS = GRAPH_NUM_BINS,
    parameter int ADDR_W   = GRAPH_ADDR_W,
    parameter int DATA_W   = GRAPH_DATA_W
) (
    input  logic              i_clk_pixel,
    input  logic              i_rst,
    input  logic              i_vsync,
    input  logic              i_freeze,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_last,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_swap_pulse,
    output logic              o_front_bank,
    output logic              o_err_short,
    output logic              o_err_long,
    output logic [7:0]        o_drop_cnt
);

    // Bank index is the RAM address MSB, so the RAM spans 2**(ADDR_W+1) words.
    localparam int                RAM_AW   = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BINS - 1);

    graph_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              r_vsync_prev;
    logic              r_front;
    logic              r_swap;
    logic              r_err_short;
    logic              r_err_long;
    logic [7:0]        r_drop;
    logic              r_rd_zero;

    logic              w_fb;
    logic              w_wr_ready;
    logic              w_acc;
    logic              w_at_end;
    logic              w_swap;
    logic              w_drop_inc;
    logic              w_set_short;
    logic              w_set_long;
    logic              w_rd_oob;
    logic [DATA_W-1:0] w_ram_q;

    assign w_fb       = r_vsync_prev & ~i_vsync;
    // Gated by reset directly so ready is low in every reset cycle, not one cycle late.
    assign w_wr_ready = (r_state == ST_FILL) & ~i_rst;
    assign w_acc      = i_wr_valid & w_wr_ready;
    assign w_at_end   = (r_ptr == LAST_PTR);

    // Out-of-range reads only exist when the address space is larger than a frame.
    if (NUM_BINS < (1 << ADDR_W)) begin : g_oob
        assign w_rd_oob = ({1'b0, i_rd_addr} >= (ADDR_W + 1)'(NUM_BINS));
    end else begin : g_no_oob
        assign w_rd_oob = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_swap      = 1'b0;
        w_drop_inc  = 1'b0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_acc) begin
                    if (i_wr_last || w_at_end) begin
                        w_state_nxt = ST_DONE;
                        w_ptr_nxt   = '0;
                        w_set_short = i_wr_last & ~w_at_end;
                        w_set_long  = w_at_end & ~i_wr_last;
                    end else begin
                        w_ptr_nxt = r_ptr + ADDR_W'(1);
                    end
                end
                // A boundary seen while filling is a dropped frame, even if the
                // final beat lands on this same edge.
                if (w_fb) begin
                    w_drop_inc = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_fb && !i_freeze) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_state      <= ST_FILL;
            r_ptr        <= '0;
            r_vsync_prev <= 1'b1;
            r_front      <= 1'b0;
            r_swap       <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_drop       <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_vsync_prev <= i_vsync;
            r_front      <= r_front ^ w_swap;
            r_swap       <= w_swap;
            r_err_short  <= r_err_short | w_set_short;
            r_err_long   <= r_err_long | w_set_long;
            if (w_drop_inc && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    // Zeroing is applied after the RAM read register so the RAM itself stays reset-free.
    always_ff @(posedge i_clk_pixel) begin
        r_rd_zero <= i_rst | w_rd_oob;
    end

    graph_bank_ram #(
        .AW (RAM_AW),
        .DW (DATA_W)
    ) u_ram (
        .i_clk     (i_clk_pixel),
        .i_wr_en   (w_acc),
        .i_wr_addr ({~r_front, r_ptr}),
        .i_wr_data (i_wr_data),
        .i_rd_addr ({r_front, i_rd_addr}),
        .o_rd_data (w_ram_q)
    );

    assign o_wr_ready   = w_wr_ready;
    assign o_rd_data    = r_rd_zero ? '0 : w_ram_q;
    assign o_swap_pulse = r_swap;
    assign o_front_bank = r_front;
    assign o_err_short  = r_err_short;
    assign o_err_long   = r_err_long;
    assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_graph_bank_ctrl.sv
// Purpose: self-checking bench for graph_bank_ctrl (frame fill, swap, errors, freeze, drops, reset).
// Latency: read expectations are queued when rd_addr is driven and popped one clock later.
// Backpressure: producer beats wait (bounded) on wr_ready.
module tb_graph_bank_ctrl;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_vsync = 1'b1;
    logic       i_freeze = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [8:0] i_wr_data = '0;
    logic       i_wr_last = 1'b0;
    logic [7:0] i_rd_addr = '0;
    logic       o_wr_ready;
    logic [8:0] o_rd_data;
    logic       o_swap_pulse;
    logic       o_front_bank;
    logic       o_err_short;
    logic       o_err_long;
    logic [7:0] o_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         phase;
        logic [7:0] addr;
        logic [8:0] exp;
    } rd_vec_t;

    rd_vec_t    tbl[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    graph_bank_ctrl dut (
        .i_clk_pixel  (clk),
        .i_rst        (i_rst),
        .i_vsync      (i_vsync),
        .i_freeze     (i_freeze),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_data    (i_wr_data),
        .i_wr_last    (i_wr_last),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_swap_pulse (o_swap_pulse),
        .o_front_bank (o_front_bank),
        .o_err_short  (o_err_short),
        .o_err_long   (o_err_long),
        .o_drop_cnt   (o_drop_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int d, input bit last);
        int w;
        i_wr_valid = 1'b1;
        i_wr_data  = d[8:0];
        i_wr_last  = last;
        w = 0;
        while (!o_wr_ready && w < 600) begin
            tick();
            w++;
        end
        if (!o_wr_ready) chk("wr_ready_wait", int'(o_wr_ready), 1);
        tick();
        i_wr_valid = 1'b0;
        i_wr_last  = 1'b0;
    endtask

    // Drives one vsync fall; returns swap_pulse as seen right after the boundary edge.
    task automatic vs_fall(output bit swp);
        i_vsync = 1'b0;
        tick();
        swp = o_swap_pulse;
        i_vsync = 1'b1;
        tick();
        chk("swap_pulse_width", int'(o_swap_pulse), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic do_reads(input int ph);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].phase == ph) begin
                i_rd_addr = tbl[i].addr;
                exp_q.push_back(tbl[i].exp);
                tick();
                if (exp_q.size() == 0) begin
                    chk("rd_queue_empty", 0, 1);
                end else begin
                    chk($sformatf("rd_p%0d_a%0d", ph, tbl[i].addr), int'(o_rd_data), int'(exp_q.pop_front()));
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit swp;

        tbl.push_back('{1, 8'd0,   9'd0});
        tbl.push_back('{1, 8'd37,  9'd37});
        tbl.push_back('{1, 8'd128, 9'd128});
        tbl.push_back('{1, 8'd255, 9'd255});
        tbl.push_back('{2, 8'd0,   9'd511});
        tbl.push_back('{2, 8'd37,  9'd474});
        tbl.push_back('{2, 8'd255, 9'd256});
        tbl.push_back('{3, 8'd50,  9'd350});
        tbl.push_back('{3, 8'd99,  9'd399});
        tbl.push_back('{3, 8'd100, 9'd100});
        tbl.push_back('{3, 8'd150, 9'd150});
        tbl.push_back('{4, 8'd0,   9'd1});
        tbl.push_back('{4, 8'd255, 9'd256});
        tbl.push_back('{5, 8'd0,   9'd500});
        tbl.push_back('{5, 8'd3,   9'd503});
        tbl.push_back('{5, 8'd4,   9'd504});
        tbl.push_back('{5, 8'd5,   9'd305});
        tbl.push_back('{6, 8'd10,  9'd20});
        tbl.push_back('{6, 8'd200, 9'd400});
        tbl.push_back('{6, 8'd255, 9'd510});
        tbl.push_back('{7, 8'd0,   9'd255});
        tbl.push_back('{7, 8'd255, 9'd0});
        tbl.push_back('{8, 8'd0,   9'd99});
        tbl.push_back('{8, 8'd49,  9'd99});
        tbl.push_back('{8, 8'd60,  9'd120});
        tbl.push_back('{9, 8'd0,   9'd77});
        tbl.push_back('{9, 8'd2,   9'd79});
        tbl.push_back('{9, 8'd3,   9'd252});

        // Reset state
        tick();
        tick();
        chk("rst_wr_ready", int'(o_wr_ready), 0);
        chk("rst_rd_data", int'(o_rd_data), 0);
        chk("rst_swap", int'(o_swap_pulse), 0);
        chk("rst_front", int'(o_front_bank), 0);
        chk("rst_err_short", int'(o_err_short), 0);
        chk("rst_err_long", int'(o_err_long), 0);
        chk("rst_drop", int'(o_drop_cnt), 0);
        i_rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(o_wr_ready), 1);

        // Two boundaries with no producer activity
        vs_fall(swp);
        chk("idle_swap1", int'(swp), 0);
        vs_fall(swp);
        chk("idle_swap2", int'(swp), 0);
        chk("idle_drop", int'(o_drop_cnt), 2);
        chk("idle_front", int'(o_front_bank), 0);

        do_reset();
        chk("rst2_drop", int'(o_drop_cnt), 0);

        // Full frame into bank 1, data = bin index
        for (int i = 0; i < 256; i++) send_beat(i, i == 255);
        chk("full_ready_done", int'(o_wr_ready), 0);
        chk("full_err_short", int'(o_err_short), 0);
        chk("full_err_long", int'(o_err_long), 0);
        vs_fall(swp);
        chk("full_swap", int'(swp), 1);
        chk("full_front", int'(o_front_bank), 1);
        chk("full_ready_after", int'(o_wr_ready), 1);
        do_reads(1);

        // Full frame into bank 0, data = 511 - index
        for (int i = 0; i < 256; i++) send_beat(511 - i, i == 255);
        vs_fall(swp);
        chk("b0_swap", int'(swp), 1);
        chk("b0_front", int'(o_front_bank), 0);
        do_reads(2);

        // Short frame: wr_last on beat 100
        for (int i = 0; i < 100; i++) send_beat(i + 300, i == 99);
        chk("short_err_short", int'(o_err_short), 1);
        chk("short_err_long", int'(o_err_long), 0);
        chk("short_ready", int'(o_wr_ready), 0);
        vs_fall(swp);
        chk("short_swap", int'(swp), 1);
        chk("short_front", int'(o_front_bank), 1);
        do_reads(3);

        // Long frame: 256 beats without wr_last, extra beats stall until the swap
        for (int i = 0; i < 256; i++) send_beat(i + 1, 1'b0);
        chk("long_err_long", int'(o_err_long), 1);
        chk("long_err_short_sticky", int'(o_err_short), 1);
        i_wr_valid = 1'b1;
        i_wr_data  = 9'd500;
        i_wr_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("long_stall%0d", k), int'(o_wr_ready), 0);
            tick();
        end
        vs_fall(swp);
        i_wr_valid = 1'b0;
        chk("long_swap", int'(swp), 1);
        chk("long_front", int'(o_front_bank), 0);
        do_reads(4);
        send_beat(501, 1'b0);
        send_beat(502, 1'b0);
        send_beat(503, 1'b0);
        send_beat(504, 1'b1);
        vs_fall(swp);
        chk("long2_swap", int'(swp), 1);
        chk("long2_front", int'(o_front_bank), 1);
        do_reads(5);

        // Freeze holds a complete frame across three boundaries
        chk("pre_freeze_drop", int'(o_drop_cnt), 0);
        for (int i = 0; i < 256; i++) send_beat((2 * i) & 511, i == 255);
        i_freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vs_fall(swp);
            chk($sformatf("freeze_swap%0d", k), int'(swp), 0);
        end
        chk("freeze_drop", int'(o_drop_cnt), 0);
        chk("freeze_front", int'(o_front_bank), 1);
        chk("freeze_ready", int'(o_wr_ready), 0);
        i_freeze = 1'b0;
        vs_fall(swp);
        chk("unfreeze_swap", int'(swp), 1);
        chk("unfreeze_front", int'(o_front_bank), 0);
        do_reads(6);

        // Final beat on the same edge as the boundary
        for (int i = 0; i < 255; i++) send_beat(255 - i, 1'b0);
        i_wr_valid = 1'b1;
        i_wr_data  = 9'd0;
        i_wr_last  = 1'b1;
        i_vsync    = 1'b0;
        tick();
        chk("coinc_swap", int'(o_swap_pulse), 0);
        chk("coinc_drop", int'(o_drop_cnt), 1);
        chk("coinc_ready", int'(o_wr_ready), 0);
        chk("coinc_front", int'(o_front_bank), 0);
        i_wr_valid = 1'b0;
        i_wr_last  = 1'b0;
        i_vsync    = 1'b1;
        tick();
        vs_fall(swp);
        chk("coinc_next_swap", int'(swp), 1);
        chk("coinc_next_front", int'(o_front_bank), 1);
        chk("coinc_next_drop", int'(o_drop_cnt), 1);
        do_reads(7);

        // Reset mid-fill at beat 50
        for (int i = 0; i < 50; i++) send_beat(99, 1'b0);
        i_rst = 1'b1;
        #1;
        chk("midrst_ready_now", int'(o_wr_ready), 0);
        tick();
        chk("midrst_ready", int'(o_wr_ready), 0);
        chk("midrst_err_short", int'(o_err_short), 0);
        chk("midrst_err_long", int'(o_err_long), 0);
        chk("midrst_drop", int'(o_drop_cnt), 0);
        chk("midrst_front", int'(o_front_bank), 0);
        i_rst = 1'b0;
        #1;
        chk("midrst_ready_after", int'(o_wr_ready), 1);
        do_reads(8);
        send_beat(77, 1'b0);
        send_beat(78, 1'b0);
        send_beat(79, 1'b1);
        chk("midrst_short", int'(o_err_short), 1);
        chk("midrst_long", int'(o_err_long), 0);
        vs_fall(swp);
        chk("midrst_swap", int'(swp), 1);
        chk("midrst_front2", int'(o_front_bank), 1);
        do_reads(9);

        if (exp_q.size() != 0) chk("rd_queue_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
